ifu_lsu_bus_arbiter: RTL

- Shares the single core-side memory bus between the instruction fetch unit (read-only) and the load/store unit (read/write).
- Sits between the IFU/LSU bus ports and the memory/crossbar port.
- Allows one outstanding transaction at a time, with round-robin grant, request hold/accept handshake and a response watchdog.
- Returns read data as a one-cycle valid pulse to the owning requester, matching the level-request / pulse-response style of the IFU bus port.

---
 rtl/ifu_lsu_bus_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ifu_lsu_bus_arbiter.sv
// Shares one core-side memory bus between the IFU (read-only) and the LSU (read/write).
// One outstanding transaction, round-robin grant, latched request fields, response watchdog.
module ifu_lsu_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic                  ifu_rvalid,
    output logic                  ifu_err,

    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_valid,
    input  logic                  lsu_write,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_rvalid,
    output logic                  lsu_err,

    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_write,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_resp_valid,
    input  logic [DATA_W-1:0]     m_rdata,

    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_COOL = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]          state;
    logic                owner;
    logic                lg;
    logic                to_flag;
    logic [CNT_W-1:0]    wd_cnt;

    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] strb_q;
    logic [DATA_W-1:0]   ifu_rdata_q;
    logic [DATA_W-1:0]   lsu_rdata_q;

    logic grant_ifu;
    logic grant_lsu;
    logic resp_now;
    logic to_now;
    logic wd_expire;

    always_comb begin
        grant_lsu = lsu_valid && (!ifu_arvalid || (lg == OWN_IFU));
        grant_ifu = ifu_arvalid && !grant_lsu;
        // An accept with a same-cycle response is delivered straight from REQ.
        resp_now  = m_resp_valid && ((state == ST_RESP) || ((state == ST_REQ) && m_ready));
        // A timeout is reported during the COOL cycle that follows expiry.
        to_now    = (state == ST_COOL) && to_flag;
        wd_expire = ((state == ST_REQ) || (state == ST_RESP)) && (wd_cnt == TO_LAST) && !resp_now;
    end

    always_comb begin
        m_valid = (state == ST_REQ);
        m_write = write_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        m_wstrb = strb_q;
        busy    = (state != ST_IDLE);

        ifu_rvalid = (resp_now || to_now) && (owner == OWN_IFU);
        ifu_err    = to_now && (owner == OWN_IFU);
        lsu_rvalid = (resp_now || to_now) && (owner == OWN_LSU);
        lsu_err    = to_now && (owner == OWN_LSU);

        ifu_rdata = ifu_rdata_q;
        if (owner == OWN_IFU) begin
            if (resp_now)    ifu_rdata = m_rdata;
            else if (to_now) ifu_rdata = '0;
        end
        lsu_rdata = lsu_rdata_q;
        if (owner == OWN_LSU) begin
            if (resp_now)    lsu_rdata = m_rdata;
            else if (to_now) lsu_rdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            owner       <= OWN_IFU;
            lg          <= OWN_IFU;
            to_flag     <= 1'b0;
            wd_cnt      <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        owner   <= grant_lsu ? OWN_LSU : OWN_IFU;
                        lg      <= grant_lsu ? OWN_LSU : OWN_IFU;
                        state   <= ST_REQ;
                        wd_cnt  <= '0;
                        to_flag <= 1'b0;
                        if (grant_lsu) begin
                            addr_q  <= lsu_addr;
                            write_q <= lsu_write;
                            wdata_q <= lsu_wdata;
                            strb_q  <= lsu_wstrb;
                        end else begin
                            addr_q  <= ifu_araddr;
                            write_q <= 1'b0;
                            wdata_q <= '0;
                            strb_q  <= '0;
                        end
                    end
                end
                ST_REQ, ST_RESP: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (resp_now) begin
                        state <= ST_COOL;
                    end else if (wd_expire) begin
                        state   <= ST_COOL;
                        to_flag <= 1'b1;
                    end else if ((state == ST_REQ) && m_ready) begin
                        state <= ST_RESP;
                    end
                end
                ST_COOL: begin
                    state   <= ST_IDLE;
                    to_flag <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            if (resp_now) begin
                if (owner == OWN_LSU) lsu_rdata_q <= m_rdata;
                else                  ifu_rdata_q <= m_rdata;
            end else if (to_now) begin
                if (owner == OWN_LSU) lsu_rdata_q <= '0;
                else                  ifu_rdata_q <= '0;
            end
        end
    end

endmodule
